// File: rtl/cnn_cfg_pkg.sv
// Shared configuration types and widths for the Fused-Block-CNN datapath.
package cnn_cfg_pkg;

  localparam int unsigned KW_W     = 4;
  localparam int unsigned DIM_W    = 8;
  localparam int unsigned STRIDE_W = 2;
  localparam int unsigned ADDR_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nest_counter.sv
// One level of a loop nest: counts 0..max on inc_en, wrap is the carry into
// the next outer level. at_max_nxt_c tells whether the next value is at max.
module nest_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [W-1:0] max,
  output logic         wrap,
  output logic         at_max_nxt_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count, carry-out and look-ahead max flag.
  always_comb begin
    cnt_d        = cnt_q;
    wrap         = inc_en && (cnt_q == max);
    if (clr) begin
      cnt_d = '0;
    end else if (inc_en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
    at_max_nxt_c = (cnt_d == max);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ifm_addr_gen.sv
// IFM SRAM read-address generator: walks every convolution window in output
// raster order and issues one word address per valid/ready handshake.
module ifm_addr_gen
  import cnn_cfg_pkg::*;
#(
  parameter int unsigned TOTAL_PE = 16,
  parameter int unsigned ADDR_W   = cnn_cfg_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KW_W-1:0]     KERNEL_W,
  input  logic [DIM_W-1:0]    IFM_W,
  input  logic [DIM_W-1:0]    IFM_C,
  input  logic [DIM_W-1:0]    OFM_W,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [31:0]         base_addr,
  output logic [ADDR_W-1:0]   addr,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic                win_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LOG2_PE = $clog2(TOTAL_PE);
  localparam int unsigned CSUM_W  = DIM_W + LOG2_PE + 1;

  state_e state_q, state_d;

  // Address pointers: origin of the current oy row of windows, of the current
  // window, and of the current kernel row. addr runs linearly along (kx, cb).
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] oy_base_q, oy_base_d;
  logic [ADDR_W-1:0] win_base_q, win_base_d;
  logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;

  // Per-layer step sizes, multiplied once at start and held.
  logic [ADDR_W-1:0] rowc_q, rowc_d;
  logic [ADDR_W-1:0] sxc_q, sxc_d;
  logic [ADDR_W-1:0] syc_q, syc_d;

  logic [KW_W-1:0]  kmax_q, kmax_d;
  logic [DIM_W-1:0] omax_q, omax_d;
  logic [DIM_W-1:0] cmax_q, cmax_d;

  logic addr_valid_q, addr_valid_d;
  logic win_last_q, win_last_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [CSUM_W-1:0] csum_c;
  logic [DIM_W-1:0]  c_blks_c;
  logic [ADDR_W-1:0] rowc_c, sxc_c, syc_c;
  logic              zero_c, hs_c, clr_c;
  logic cb_wrap, kx_wrap, ky_wrap, ox_wrap, oy_wrap;
  logic cb_at_max, kx_at_max, ky_at_max, ox_at_max, oy_at_max;
  logic unused_at_max_c;

  // Layer geometry derived from the start-cycle inputs.
  always_comb begin
    csum_c   = CSUM_W'(IFM_C) + CSUM_W'(TOTAL_PE - 1);
    c_blks_c = DIM_W'(csum_c >> LOG2_PE);
    rowc_c   = ADDR_W'(IFM_W) * ADDR_W'(c_blks_c);
    sxc_c    = ADDR_W'(stride) * ADDR_W'(c_blks_c);
    syc_c    = rowc_c * ADDR_W'(stride);
    zero_c   = (OFM_W == '0) || (KERNEL_W == '0) || (IFM_C == '0);
  end

  assign hs_c  = addr_valid_q && addr_ready;
  assign clr_c = (state_q == IDLE) && start;

  nest_counter #(.W(DIM_W)) u_cb (
    .clk(clk), .rst(rst), .clr(clr_c), .inc_en(hs_c), .max(cmax_q),
    .wrap(cb_wrap), .at_max_nxt_c(cb_at_max)
  );
  nest_counter #(.W(KW_W)) u_kx (
    .clk(clk), .rst(rst), .clr(clr_c), .inc_en(cb_wrap), .max(kmax_q),
    .wrap(kx_wrap), .at_max_nxt_c(kx_at_max)
  );
  nest_counter #(.W(KW_W)) u_ky (
    .clk(clk), .rst(rst), .clr(clr_c), .inc_en(kx_wrap), .max(kmax_q),
    .wrap(ky_wrap), .at_max_nxt_c(ky_at_max)
  );
  nest_counter #(.W(DIM_W)) u_ox (
    .clk(clk), .rst(rst), .clr(clr_c), .inc_en(ky_wrap), .max(omax_q),
    .wrap(ox_wrap), .at_max_nxt_c(ox_at_max)
  );
  nest_counter #(.W(DIM_W)) u_oy (
    .clk(clk), .rst(rst), .clr(clr_c), .inc_en(ox_wrap), .max(omax_q),
    .wrap(oy_wrap), .at_max_nxt_c(oy_at_max)
  );

  assign unused_at_max_c = ox_at_max & oy_at_max;

  // Next-state, config capture and next-address precompute.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    oy_base_d    = oy_base_q;
    win_base_d   = win_base_q;
    row_ptr_d    = row_ptr_q;
    rowc_d       = rowc_q;
    sxc_d        = sxc_q;
    syc_d        = syc_q;
    kmax_d       = kmax_q;
    omax_d       = omax_q;
    cmax_d       = cmax_q;
    addr_valid_d = addr_valid_q;
    win_last_d   = win_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          kmax_d = KERNEL_W - KW_W'(1);
          omax_d = OFM_W - DIM_W'(1);
          cmax_d = c_blks_c - DIM_W'(1);
          rowc_d = rowc_c;
          sxc_d  = sxc_c;
          syc_d  = syc_c;
          busy_d = 1'b1;
          if (zero_c) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = RUN;
            addr_valid_d = 1'b1;
            addr_d       = ADDR_W'(base_addr);
            oy_base_d    = ADDR_W'(base_addr);
            win_base_d   = ADDR_W'(base_addr);
            row_ptr_d    = ADDR_W'(base_addr);
            win_last_d   = (KERNEL_W == KW_W'(1)) && (c_blks_c == DIM_W'(1));
          end
        end
      end

      RUN: begin
        if (hs_c) begin
          if (oy_wrap) begin
            state_d      = DONE;
            addr_valid_d = 1'b0;
            win_last_d   = 1'b0;
            done_d       = 1'b1;
          end else begin
            win_last_d = ky_at_max && kx_at_max && cb_at_max;
            if (!kx_wrap) begin
              // (kx, cb) are contiguous within one kernel row.
              addr_d = addr_q + ADDR_W'(1);
            end else if (!ky_wrap) begin
              row_ptr_d = row_ptr_q + rowc_q;
              addr_d    = row_ptr_q + rowc_q;
            end else if (!ox_wrap) begin
              win_base_d = win_base_q + sxc_q;
              row_ptr_d  = win_base_q + sxc_q;
              addr_d     = win_base_q + sxc_q;
            end else begin
              oy_base_d  = oy_base_q + syc_q;
              win_base_d = oy_base_q + syc_q;
              row_ptr_d  = oy_base_q + syc_q;
              addr_d     = oy_base_q + syc_q;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, outputs and latched layer config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      oy_base_q    <= '0;
      win_base_q   <= '0;
      row_ptr_q    <= '0;
      rowc_q       <= '0;
      sxc_q        <= '0;
      syc_q        <= '0;
      kmax_q       <= '0;
      omax_q       <= '0;
      cmax_q       <= '0;
      addr_valid_q <= 1'b0;
      win_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      oy_base_q    <= oy_base_d;
      win_base_q   <= win_base_d;
      row_ptr_q    <= row_ptr_d;
      rowc_q       <= rowc_d;
      sxc_q        <= sxc_d;
      syc_q        <= syc_d;
      kmax_q       <= kmax_d;
      omax_q       <= omax_d;
      cmax_q       <= cmax_d;
      addr_valid_q <= addr_valid_d;
      win_last_q   <= win_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign win_last   = win_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ifm_addr_gen.sv
// Self-checking bench for ifm_addr_gen against a loop-nest reference model.
module tb_ifm_addr_gen;

  localparam int PE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  KERNEL_W;
  logic [7:0]  IFM_W;
  logic [7:0]  IFM_C;
  logic [7:0]  OFM_W;
  logic [1:0]  stride;
  logic [31:0] base_addr;
  logic [31:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic        win_last;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic        l;
  } exp_t;

  exp_t exp_q[$];

  ifm_addr_gen #(.TOTAL_PE(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .KERNEL_W(KERNEL_W), .IFM_W(IFM_W), .IFM_C(IFM_C), .OFM_W(OFM_W),
    .stride(stride), .base_addr(base_addr),
    .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .win_last(win_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected address stream straight from the window/channel formula.
  task automatic build_model(input int k, input int s, input int iw, input int ow,
                             input int c, input logic [31:0] base);
    int   nb;
    longint idx;
    exp_t e;
    nb = (c + PE - 1) / PE;
    exp_q.delete();
    for (int oy = 0; oy < ow; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++)
            for (int b = 0; b < nb; b++) begin
              idx = longint'((oy * s + ky) * iw + ox * s + kx) * longint'(nb) + longint'(b);
              e.a = base + 32'(idx);
              e.l = (ky == k - 1) && (kx == k - 1) && (b == nb - 1);
              exp_q.push_back(e);
            end
  endtask

  task automatic drive_cfg(input int k, input int s, input int iw, input int ow,
                           input int c, input logic [31:0] base);
    KERNEL_W  = 4'(k);
    stride    = 2'(s);
    IFM_W     = 8'(iw);
    OFM_W     = 8'(ow);
    IFM_C     = 8'(c);
    base_addr = base;
  endtask

  task automatic scramble();
    KERNEL_W  = 4'($urandom);
    stride    = 2'($urandom);
    IFM_W     = 8'($urandom);
    OFM_W     = 8'($urandom);
    IFM_C     = 8'($urandom);
    base_addr = $urandom;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_addr"}, addr, 32'd0);
    chk({pfx, "_valid"}, 32'(addr_valid), 32'd0);
    chk({pfx, "_win_last"}, 32'(win_last), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
  endtask

  // One layer walk; called and returns at a sample point (#1 after posedge).
  task automatic run_walk(input int k, input int s, input int iw, input int ow, input int c,
                          input logic [31:0] base, input bit bp, input int repulse_at,
                          input bit sod, input int abort_at,
                          output int n_hs, output logic [31:0] last_addr);
    logic        pv, pr, pw;
    logic [31:0] pa;
    bit          r;
    int          cycles, budget;
    exp_t        e;
    build_model(k, s, iw, ow, c, base);
    budget    = 4 * exp_q.size() + 20;
    n_hs      = 0;
    last_addr = '0;
    pv = 1'b0; pr = 1'b0; pw = 1'b0; pa = '0;
    cycles = 0;
    drive_cfg(k, s, iw, ow, c, base);
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    chk("first_valid", 32'(addr_valid), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    while (exp_q.size() > 0 && cycles < budget) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(addr_valid), 32'd1);
        chk("hold_addr", addr, pa);
        chk("hold_win_last", 32'(win_last), 32'(pw));
      end
      r = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      addr_ready = r;
      pv = addr_valid; pr = r; pa = addr; pw = win_last;
      if (addr_valid && r) begin
        e = exp_q.pop_front();
        chk("addr", addr, e.a);
        chk("win_last", 32'(win_last), 32'(e.l));
        n_hs++;
        last_addr = addr;
        if (n_hs == repulse_at) begin
          start     = 1'b1;
          base_addr = ~base;
        end
        if (n_hs == abort_at) begin
          tick();
          start = 1'b0;
          rst   = 1'b1;
          #1;
          check_reset_outputs("abort");
          repeat (3) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
          end
          rst        = 1'b0;
          addr_ready = 1'b1;
          return;
        end
      end
      tick();
      start = 1'b0;
      cycles++;
    end
    chk("walk_complete", 32'(exp_q.size()), 32'd0);
    chk("end_valid", 32'(addr_valid), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    if (sod) begin
      drive_cfg(1, 1, 4, 1, 16, 32'h77);
      start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk("done_low", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("idle_valid", 32'(addr_valid), 32'd0);
    addr_ready = 1'b1;
  endtask

  // Zero-size layer: done next cycle, no address.
  task automatic run_zero(input int k, input int ow, input int c);
    drive_cfg(k, 1, 4, ow, c, 32'h55);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_valid", 32'(addr_valid), 32'd0);
    tick();
    chk("zero_done_low", 32'(done), 32'd0);
    chk("zero_busy_low", 32'(busy), 32'd0);
    chk("zero_valid_low", 32'(addr_valid), 32'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] last;
    int          rk, rs, ro, rc, riw;

    rst        = 1'b1;
    start      = 1'b0;
    addr_ready = 1'b1;
    drive_cfg(0, 0, 0, 0, 0, 32'h0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic walk.
    run_walk(3, 1, 4, 2, 16, 32'h100, 1'b0, -1, 1'b0, -1, n, last);
    chk("basic_count", 32'(n), 32'd36);
    chk("basic_last", last, 32'h10F);

    // Stride 2.
    run_walk(3, 2, 5, 2, 16, 32'h0, 1'b0, -1, 1'b0, -1, n, last);
    chk("stride2_count", 32'(n), 32'd36);
    chk("stride2_last", last, 32'h18);

    // Channel blocking, C_BLKS = 2.
    run_walk(1, 1, 2, 2, 20, 32'h0, 1'b0, -1, 1'b0, -1, n, last);
    chk("cblk_count", 32'(n), 32'd8);
    chk("cblk_last", last, 32'h7);

    // Backpressure on the basic walk.
    run_walk(3, 1, 4, 2, 16, 32'h100, 1'b1, -1, 1'b0, -1, n, last);
    chk("bp_count", 32'(n), 32'd36);
    chk("bp_last", last, 32'h10F);

    // Zero-size layers.
    run_zero(3, 0, 16);
    run_zero(0, 2, 16);
    run_zero(3, 2, 0);

    // Reset after 10 handshakes, then a fresh walk.
    run_walk(3, 1, 4, 2, 16, 32'h100, 1'b0, -1, 1'b0, 10, n, last);
    run_walk(3, 1, 4, 2, 16, 32'h100, 1'b0, -1, 1'b0, -1, n, last);
    chk("post_rst_count", 32'(n), 32'd36);
    chk("post_rst_last", last, 32'h10F);

    // start re-pulsed mid-walk and in the done cycle.
    run_walk(3, 1, 4, 2, 16, 32'h100, 1'b1, 5, 1'b1, -1, n, last);
    chk("repulse_count", 32'(n), 32'd36);
    chk("repulse_last", last, 32'h10F);

    // Randomised geometries with backpressure.
    for (int i = 0; i < 8; i++) begin
      rk  = int'($urandom_range(1, 3));
      rs  = int'($urandom_range(1, 3));
      ro  = int'($urandom_range(1, 3));
      rc  = int'($urandom_range(1, 40));
      riw = (ro - 1) * rs + rk + int'($urandom_range(0, 2));
      run_walk(rk, rs, riw, ro, rc, $urandom, 1'b1, -1, 1'b0, -1, n, last);
      chk("rand_count", 32'(n), 32'(ro * ro * rk * rk * ((rc + PE - 1) / PE)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifm_addr_gen.md
# ifm_addr_gen

Input-feature-map read-address generator, directly downstream of `control_unit` in the Fused-Block-CNN datapath. On a start pulse it latches the layer geometry and walks every convolution window in output-raster order. It emits one IFM SRAM word address per accepted handshake, where each word holds `TOTAL_PE` channels. The addresses feed the IFM buffer read port that supplies the PE array.

## Interface
Parameters:
- `TOTAL_PE`, 16: channels packed per SRAM word. Power of two.
- `ADDR_W`, 32: address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle layer start, driven from `control_unit` (`cal_start`).
- `KERNEL_W`  in  4  kernel width and height (square kernel).
- `IFM_W`  in  8  input map width; the input map is square.
- `IFM_C`  in  8  input channels.
- `OFM_W`  in  8  output map width and height.
- `stride`  in  2  convolution stride, 1..3.
- `base_addr`  in  32  IFM base word address.
- `addr`  out  ADDR_W  current read address.
- `addr_valid`  out  1  `addr` is valid.
- `addr_ready`  in  1  consumer accepts `addr`.
- `win_last`  out  1  `addr` is the last word of the current window.
- `busy`  out  1  a layer walk is in progress.
- `done`  out  1  one-cycle pulse after the final address is accepted.

## Operation
- `C_BLKS = ceil(IFM_C / TOTAL_PE)`, computed as `(IFM_C + TOTAL_PE-1) >> log2(TOTAL_PE)`.
- Loop nest, outermost to innermost: `oy`, `ox`, `ky`, `kx`, `cb`, each counting from 0.
  - `oy` and `ox` run to `OFM_W-1`.
  - `ky` and `kx` run to `KERNEL_W-1`.
  - `cb` runs to `C_BLKS-1`.
- Address calculation:
  - `iy = oy*stride + ky`
  - `ix = ox*stride + kx`
  - `addr = base_addr + (iy*IFM_W + ix)*C_BLKS + cb`, truncated modulo 2^ADDR_W.
- Total addresses per layer: `OFM_W² · KERNEL_W² · C_BLKS`.
- No padding. The bounds check `iy, ix < IFM_W` is the configuring software's responsibility and is not checked here.
- `win_last` is high when `ky`, `kx` and `cb` are all at their maximum.
- All config inputs are latched on the accepted `start`. Later changes to the inputs have no effect until the next `start`.
- State machine:
  - IDLE: `start` → RUN. If `OFM_W`, `KERNEL_W` or `IFM_C` is 0, `start` → DONE instead, and no address is emitted.
  - RUN: on `addr_valid && addr_ready`, advance the innermost counter with carry into the outer counters. When the final address is accepted → DONE.
  - DONE: `done` = 1 for one cycle → IDLE.
- `start` is ignored while in RUN or DONE.

## Timing
- Reset values: `addr`=0, `addr_valid`=0, `win_last`=0, `busy`=0, `done`=0. All counters and latched config reset to 0 and the FSM to IDLE.
- A `start` in cycle N gives `addr_valid`=1 with the first address (`base_addr`) in cycle N+1.
- Throughput is one address per cycle while `addr_ready`=1.
- `addr` and `win_last` are registered outputs.
- Valid/ready rule: while `addr_valid && !addr_ready`, `addr`, `win_last` and `addr_valid` must be held stable. `addr_valid` never drops without a handshake.
- After the final handshake in cycle M:
  - `addr_valid`=0 in M+1.
  - `done`=1 in M+1 only.
  - `busy`=0 from M+2.
- `busy`=1 from the cycle after `start` through the `done` cycle inclusive.
- Zero-size layer: `start` in N gives `done`=1 in N+1, `busy`=1 in N+1 only, and `addr_valid` stays 0.
- A `start` arriving in the same cycle as `done` is ignored.
- Reset asserted mid-walk clears everything immediately (asynchronous reset). No `done` pulse is produced.
- Multiplies are registered, one pipeline stage. Required latency is still one cycle from handshake to next `addr`, achieved by precomputing the next address in parallel with the counters.

## Structure
- A shared package `cnn_cfg_pkg` holds:
  - the FSM state enum {IDLE, RUN, DONE};
  - the config field widths (`KW_W`=4, `DIM_W`=8, `STRIDE_W`=2);
  - `ADDR_W`.
- A natural sub-module is `nest_counter`: one loop counter with `max`, `inc_en`, `wrap` (carry-out) and a synchronous clear. It is instantiated five times in a carry chain.

## Test plan
- Basic walk with `TOTAL_PE`=16, `KERNEL_W`=3, `stride`=1, `IFM_W`=4, `OFM_W`=2, `IFM_C`=16, `base_addr`=0x100, `addr_ready`=1:
  - first window is 0x100, 101, 102, 104, 105, 106, 108, 109, 10A, with `win_last` on 0x10A;
  - 36 addresses in total, the last being 0x10F;
  - `done` pulses one cycle after the final handshake.
- Stride 2 with `IFM_W`=5, `OFM_W`=2, K=3, C=16, base 0:
  - window 1 starts at 0x002;
  - window 2 starts at 0x00A;
  - final address is 0x018.
- Channel blocking with `IFM_C`=20 (so `C_BLKS`=2), K=1, `OFM_W`=2, `IFM_W`=2, base 0:
  - address sequence 0,1,2,3,4,5,6,7;
  - `win_last` on every odd address.
- Backpressure: toggle `addr_ready` pseudo-randomly during the basic walk.
  - `addr` and `win_last` are stable whenever valid is high and ready is low.
  - The accepted sequence is identical to the basic walk.
- Zero and abort cases:
  - `OFM_W`=0 → `done` in N+1 and no `addr_valid`.
  - `rst` asserted after 10 handshakes → all outputs 0 immediately, with no `done`.
  - A fresh `start` after reset reproduces the sequence from `base_addr`.
- `start` re-pulsed while busy, with `base_addr` changed → ignored. The current sequence is unaffected.
